// File: rtl/dsa_pixel_fetch_unit_if.sv
// Pipelined pixel-memory read port: strobe + address out, data back MEM_LATENCY cycles later.
interface dsa_pixel_fetch_unit_if #(
    parameter int ADDR_WIDTH = 18
);
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_rdata;

    modport master (output mem_rd_en, output mem_addr, input mem_rdata);
    modport slave  (input mem_rd_en, input mem_addr, output mem_rdata);
endinterface

// File: rtl/dsa_pixel_fetch_unit.sv
// Bilinear neighbour fetch: maps an output coordinate to four clamped source pixels.
// Optional completed-fetch counter enabled by defining DSA_FETCH_PERF_CNT_EN.
module dsa_pixel_fetch_unit #(
    parameter int ADDR_WIDTH  = 18,
    parameter int MEM_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fetch_req,
    input  logic [15:0]            current_x,
    input  logic [15:0]            current_y,
    input  logic [15:0]            img_width_in,
    input  logic [15:0]            img_height_in,
    input  logic [15:0]            scale_x_inv,
    input  logic [15:0]            scale_y_inv,
    dsa_pixel_fetch_unit_if.master mem,
    output logic [7:0]             p00,
    output logic [7:0]             p01,
    output logic [7:0]             p10,
    output logic [7:0]             p11,
    output logic [7:0]             frac_x,
    output logic [7:0]             frac_y,
    output logic                   fetch_done,
    output logic                   busy,
    output logic [31:0]            fetch_count
);
    typedef enum logic [2:0] {ST_IDLE, ST_CALC, ST_ADDR, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

    state_t                  state_q, state_d;
    logic [15:0]             cx_q, cx_d, cy_q, cy_d, w_q, w_d, h_q, h_d, sx_q, sx_d, sy_q, sy_d;
    logic [15:0]             x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic [ADDR_WIDTH-1:0]   r0_q, r0_d, r1_q, r1_d;
    logic [1:0]              iss_cnt_q, iss_cnt_d, cap_cnt_q, cap_cnt_d;
    logic [MEM_LATENCY-1:0]  vld_pipe_q, vld_pipe_d;
    logic [7:0]              p00_q, p00_d, p01_q, p01_d, p10_q, p10_d, p11_q, p11_d;
    logic [7:0]              frac_x_q, frac_x_d, frac_y_q, frac_y_d;
    logic                    done_q, done_d, busy_q, busy_d;

    logic [31:0]             prod_x, prod_y;
    logic [15:0]             wm1, hm1;
    logic                    cap_fire;
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   rd_addr;

    // Integer part saturates to lim when it overflows 16 bits or leaves the image.
    function automatic logic [15:0] clamp_int(input logic [31:0] prod, input logic [15:0] lim);
        if (prod[31:24] != 8'd0 || prod[23:8] > lim) return lim;
        return prod[23:8];
    endfunction

    function automatic logic [15:0] next_clamped(input logic [15:0] v, input logic [15:0] lim);
        return (v < lim) ? v + 16'd1 : lim;
    endfunction

    // Read port is a pure decode of registered state, so it is quiet outside ST_ISSUE.
    always_comb begin
        rd_en   = (state_q == ST_ISSUE);
        rd_addr = '0;
        if (rd_en)
            rd_addr = (iss_cnt_q[1] ? r1_q : r0_q) + ADDR_WIDTH'(iss_cnt_q[0] ? x1_q : x0_q);
    end

    assign mem.mem_rd_en = rd_en;
    assign mem.mem_addr  = rd_addr;

    always_comb begin
        state_d    = state_q;
        cx_d       = cx_q;   cy_d = cy_q;   w_d = w_q;   h_d = h_q;
        sx_d       = sx_q;   sy_d = sy_q;
        x0_d       = x0_q;   x1_d = x1_q;   y0_d = y0_q; y1_d = y1_q;
        r0_d       = r0_q;   r1_d = r1_q;
        iss_cnt_d  = iss_cnt_q;
        cap_cnt_d  = cap_cnt_q;
        p00_d      = p00_q;  p01_d = p01_q; p10_d = p10_q; p11_d = p11_q;
        frac_x_d   = frac_x_q;
        frac_y_d   = frac_y_q;
        prod_x     = 32'(cx_q) * 32'(sx_q);
        prod_y     = 32'(cy_q) * 32'(sy_q);
        wm1        = w_q - 16'd1;
        hm1        = h_q - 16'd1;
        cap_fire   = vld_pipe_q[MEM_LATENCY-1];
        vld_pipe_d = vld_pipe_q << 1;
        vld_pipe_d[0] = rd_en;

        // Returned data lands in issue order: p00, p01, p10, p11.
        if (cap_fire) begin
            cap_cnt_d = cap_cnt_q + 2'd1;
            case (cap_cnt_q)
                2'd0:    p00_d = mem.mem_rdata;
                2'd1:    p01_d = mem.mem_rdata;
                2'd2:    p10_d = mem.mem_rdata;
                default: p11_d = mem.mem_rdata;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (fetch_req) begin
                    cx_d = current_x;    cy_d = current_y;
                    w_d  = img_width_in; h_d  = img_height_in;
                    sx_d = scale_x_inv;  sy_d = scale_y_inv;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                x0_d     = clamp_int(prod_x, wm1);
                y0_d     = clamp_int(prod_y, hm1);
                x1_d     = next_clamped(clamp_int(prod_x, wm1), wm1);
                y1_d     = next_clamped(clamp_int(prod_y, hm1), hm1);
                frac_x_d = prod_x[7:0];
                frac_y_d = prod_y[7:0];
                if (w_q == 16'd0 || h_q == 16'd0) begin
                    p00_d = '0; p01_d = '0; p10_d = '0; p11_d = '0;
                    frac_x_d = '0;
                    frac_y_d = '0;
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                r0_d      = ADDR_WIDTH'(y0_q) * ADDR_WIDTH'(w_q);
                r1_d      = ADDR_WIDTH'(y1_q) * ADDR_WIDTH'(w_q);
                iss_cnt_d = '0;
                state_d   = ST_ISSUE;
            end
            ST_ISSUE: begin
                iss_cnt_d = iss_cnt_q + 2'd1;
                if (iss_cnt_q == 2'd3) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cap_fire && cap_cnt_q == 2'd3) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        done_d = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cx_q <= '0; cy_q <= '0; w_q <= '0; h_q <= '0; sx_q <= '0; sy_q <= '0;
            x0_q <= '0; x1_q <= '0; y0_q <= '0; y1_q <= '0;
            r0_q <= '0; r1_q <= '0;
            iss_cnt_q  <= '0;
            cap_cnt_q  <= '0;
            vld_pipe_q <= '0;
            p00_q <= '0; p01_q <= '0; p10_q <= '0; p11_q <= '0;
            frac_x_q   <= '0;
            frac_y_q   <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cx_q <= cx_d; cy_q <= cy_d; w_q <= w_d; h_q <= h_d; sx_q <= sx_d; sy_q <= sy_d;
            x0_q <= x0_d; x1_q <= x1_d; y0_q <= y0_d; y1_q <= y1_d;
            r0_q <= r0_d; r1_q <= r1_d;
            iss_cnt_q  <= iss_cnt_d;
            cap_cnt_q  <= cap_cnt_d;
            vld_pipe_q <= vld_pipe_d;
            p00_q <= p00_d; p01_q <= p01_d; p10_q <= p10_d; p11_q <= p11_d;
            frac_x_q   <= frac_x_d;
            frac_y_q   <= frac_y_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign p00        = p00_q;
    assign p01        = p01_q;
    assign p10        = p10_q;
    assign p11        = p11_q;
    assign frac_x     = frac_x_q;
    assign frac_y     = frac_y_q;
    assign fetch_done = done_q;
    assign busy       = busy_q;

`ifdef DSA_FETCH_PERF_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb cnt_d = cnt_q + {31'd0, done_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign fetch_count = cnt_q;
`else
    assign fetch_count = '0;
`endif
endmodule

// File: doc/dsa_pixel_fetch_unit.md
Name: dsa_pixel_fetch_unit

Overview:
- Neighbour-fetch stage feeding the sequential control FSM and the interpolation datapath.
- On each fetch_req it:
  - maps the output coordinate (current_x, current_y) to a source coordinate using fixed-point inverse scale factors;
  - clamps the four bilinear neighbours to the input image;
  - reads them from a synchronous pixel memory over a pipelined read port;
  - presents p00/p01/p10/p11 plus frac_x/frac_y, then pulses fetch_done.

Parameters:
- ADDR_WIDTH, 18, pixel memory address width (512x512 max).
- MEM_LATENCY, 1, read latency in cycles from mem_rd_en to valid mem_rdata (1..4).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- fetch_req  in  1  start fetch; sampled only in ST_IDLE
- current_x  in  16  output-pixel x
- current_y  in  16  output-pixel y
- img_width_in  in  16  source width W
- img_height_in  in  16  source height H
- scale_x_inv  in  16  Q8.8 in_width/out_width
- scale_y_inv  in  16  Q8.8 in_height/out_height
- mem_rd_en  out  1  read strobe
- mem_addr  out  ADDR_WIDTH  read address
- mem_rdata  in  8  read data
- p00, p01, p10, p11  out  8 each  neighbours (x0,y0), (x1,y0), (x0,y1), (x1,y1)
- frac_x, frac_y  out  8  Q0.8 fractions
- fetch_done  out  1  one-cycle completion pulse
- busy  out  1  high when state != ST_IDLE
- fetch_count  out  32  completed-fetch counter (see Optional Feature)

Behaviour:
- Reset (rst_n low, async):
  - state ST_IDLE.
  - All outputs 0.
  - Capture valid pipeline and capture counter cleared; in-flight read data discarded.
- Input latching:
  - current_x/y, dims and scales are latched on the fetch_req cycle.
  - Later changes to these inputs have no effect on the fetch in progress.
- States:
  - ST_IDLE: fetch_req=1 -> ST_CALC.
  - ST_CALC:
    - prod_x = current_x*scale_x_inv (32-bit); likewise prod_y.
    - x_int = prod_x[23:8]; frac_x = prod_x[7:0].
    - If prod_x[31:24]!=0 or x_int>W-1, then x0=W-1; otherwise x0=x_int.
    - x1 = min(x0+1, W-1). Y axis identical.
    - All registered.
    - If W==0 or H==0 -> ST_DONE, with p* and frac cleared to 0 and no reads issued. Otherwise -> ST_ADDR.
  - ST_ADDR: register row bases r0=y0*W and r1=y1*W, truncated to ADDR_WIDTH -> ST_ISSUE.
  - ST_ISSUE:
    - 4 consecutive cycles with mem_rd_en=1.
    - mem_addr in order r0+x0, r0+x1, r1+x0, r1+x1.
    - A 2-bit issue counter wraps to 0 -> ST_WAIT.
  - ST_WAIT: remain until the 4th capture -> ST_DONE.
  - ST_DONE: fetch_done=1 for exactly one cycle -> ST_IDLE.
- Capture:
  - A MEM_LATENCY-deep valid shift register tags each issued read.
  - Data is registered into p00, p01, p10, p11 in issue order when its tag emerges.
- Output stability:
  - p*, frac_x and frac_y are stable from the fetch_done cycle until the next fetch reaches ST_CALC (frac) or ST_ISSUE capture (p*).
- Latency:
  - fetch_req sampled in cycle 0.
  - fetch_done in cycle 7+MEM_LATENCY (cycle 8 for the default).
  - Zero-dimension fetch: fetch_done in cycle 2.
- Request and strobe rules:
  - fetch_req while busy is ignored; no queueing.
  - fetch_req in the cycle after fetch_done is accepted.
  - mem_rd_en=0 and mem_addr=0 outside ST_ISSUE.

Optional Feature:
- Macro DSA_FETCH_PERF_CNT_EN.
- Defined: fetch_count increments by 1 on every fetch_done, wraps from 0xFFFFFFFF to 0, and clears on reset.
- Undefined: no counter logic; fetch_count is tied to 0.
- Port list is identical in both builds.

Test Plan:
- Memory model mem[a]=a[7:0]; W=H=4; scale inv 0x0080 (2x upscale); dst (3,5); MEM_LATENCY=1:
  - x0=1, x1=2, y0=2, y1=3; frac_x=frac_y=0x80;
  - addresses 9, 10, 13, 14 on 4 consecutive cycles;
  - p00=9, p01=10, p10=13, p11=14;
  - fetch_done exactly in cycle 8, one cycle wide.
- Edge clamp: W=H=4, inv 0x0100, dst (3,3) -> addresses 15, 15, 15, 15; all p*=15; frac 0. Overflow case: dst (0xFFFF,0) with inv 0x0200 -> x0=x1=3, addresses 3, 3, 7, 7.
- MEM_LATENCY=3 build, same stimulus as test 1 -> identical p* values; fetch_done in cycle 10.
- fetch_req held high throughout -> second fetch starts in the cycle after fetch_done; no request is accepted while busy. With DSA_FETCH_PERF_CNT_EN, fetch_count=2 after two fetches.
- rst_n low during the 3rd ST_ISSUE cycle:
  - outputs 0 immediately; no fetch_done for the aborted fetch;
  - late mem_rdata is not captured;
  - the next fetch completes normally.
- img_width_in=0 -> no mem_rd_en; p*=0, frac=0; fetch_done in cycle 2.
